// File: rtl/ecc_26_pkg.sv
// ecc_26_pkg: widths, SECDED column codes, codeword layout ({parity, data}) and the injection flip-mask helper
package ecc_26_pkg;
  localparam int DATA_WIDTH = 26;
  localparam int PARITY_WIDTH = 6;
  localparam int CW_WIDTH = DATA_WIDTH + PARITY_WIDTH;
  localparam int POS_WIDTH = $clog2(CW_WIDTH);
  localparam int PAR_POS0 = DATA_WIDTH;
  localparam logic [PARITY_WIDTH-1:0] COL_CODE [DATA_WIDTH] = '{
    6'h23, 6'h25, 6'h26, 6'h07, 6'h29, 6'h2A, 6'h0B, 6'h2C, 6'h0D, 6'h0E, 6'h2F, 6'h31, 6'h32,
    6'h13, 6'h34, 6'h15, 6'h16, 6'h37, 6'h38, 6'h19, 6'h1A, 6'h3B, 6'h1C, 6'h3D, 6'h3E, 6'h1F
  };
  function automatic logic [CW_WIDTH-1:0] flip_mask(input logic [POS_WIDTH-1:0] pos_a,
                                                    input logic [POS_WIDTH-1:0] pos_b,
                                                    input logic dbl);
    flip_mask = (CW_WIDTH'(1) << pos_a) | (dbl ? CW_WIDTH'(1) << pos_b : '0);
  endfunction
endpackage

// File: rtl/ecc_26_enc_pipe_if.sv
// ecc_26_enc_pipe_if: input (valid/ready/data) and output (valid/ready/data/parity) handshake bundle; slave = encoder side
interface ecc_26_enc_pipe_if;
  import ecc_26_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [PARITY_WIDTH-1:0] out_parity;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_parity);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_parity);
endinterface

// File: rtl/ecc_26_enc.sv
// ecc_26_enc: combinational SECDED parity generator; data in, parity out
module ecc_26_enc
  import ecc_26_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [PARITY_WIDTH-1:0] parity
);
  always_comb begin
    parity = '0;
    for (int i = 0; i < DATA_WIDTH; i++) parity = parity ^ (data[i] ? COL_CODE[i] : '0);
  end
endmodule

// File: rtl/ecc_26_enc_pipe.sv
// ecc_26_enc_pipe: SECDED encoder into a 2-entry output buffer; ports: bus (in/out handshake), inj_* error injection, clr_cnt/enc_cnt accept counter
module ecc_26_enc_pipe #(
  parameter int DATA_WIDTH = ecc_26_pkg::DATA_WIDTH,
  parameter int PARITY_WIDTH = ecc_26_pkg::PARITY_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  ecc_26_enc_pipe_if.slave bus,
  input  logic inj_arm,
  input  logic inj_dbl,
  input  logic [ecc_26_pkg::POS_WIDTH-1:0] inj_pos_a,
  input  logic [ecc_26_pkg::POS_WIDTH-1:0] inj_pos_b,
  output logic inj_pending,
  output logic inj_done,
  input  logic clr_cnt,
  output logic [15:0] enc_cnt
);
  import ecc_26_pkg::*;
  localparam int CW = DATA_WIDTH + PARITY_WIDTH;
  logic [CW-1:0] mem_q [2];
  logic [CW-1:0] mem_d [2];
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] occ_q, occ_d;
  logic inj_pending_q, inj_pending_d, inj_done_q, inj_done_d, inj_dbl_q, inj_dbl_d;
  logic [POS_WIDTH-1:0] inj_pos_a_q, inj_pos_a_d, inj_pos_b_q, inj_pos_b_d;
  logic [15:0] enc_cnt_q, enc_cnt_d;
  logic [PARITY_WIDTH-1:0] parity;
  logic [CW-1:0] cw, head;
  logic acc, drn;
  ecc_26_enc u_enc (.data(bus.in_data), .parity(parity));
  assign bus.in_ready = occ_q != 2'd2;
  assign bus.out_valid = occ_q != 2'd0;
  assign head = mem_q[rd_ptr_q];
  assign bus.out_data = head[DATA_WIDTH-1:0];
  assign bus.out_parity = head[PAR_POS0 +: PARITY_WIDTH];
  assign inj_pending = inj_pending_q;
  assign inj_done = inj_done_q;
  assign enc_cnt = enc_cnt_q;
  always_comb begin
    acc = bus.in_valid && occ_q != 2'd2;
    drn = occ_q != 2'd0 && bus.out_ready;
    cw = {parity, bus.in_data} ^ (inj_pending_q ? flip_mask(inj_pos_a_q, inj_pos_b_q, inj_dbl_q) : '0);
    mem_d = mem_q;
    if (acc) mem_d[wr_ptr_q] = cw;
    wr_ptr_d = wr_ptr_q ^ acc;
    rd_ptr_d = rd_ptr_q ^ drn;
    occ_d = occ_q + {1'b0, acc} - {1'b0, drn};
    inj_pending_d = inj_arm || (inj_pending_q && !acc);
    inj_done_d = acc && inj_pending_q;
    inj_dbl_d = inj_arm ? inj_dbl : inj_dbl_q;
    inj_pos_a_d = inj_arm ? inj_pos_a : inj_pos_a_q;
    inj_pos_b_d = inj_arm ? inj_pos_b : inj_pos_b_q;
    enc_cnt_d = clr_cnt ? '0 : (acc && enc_cnt_q != 16'hFFFF) ? enc_cnt_q + 16'd1 : enc_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q <= '0;
      inj_pending_q <= 1'b0;
      inj_done_q <= 1'b0;
      inj_dbl_q <= 1'b0;
      inj_pos_a_q <= '0;
      inj_pos_b_q <= '0;
      enc_cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q <= occ_d;
      inj_pending_q <= inj_pending_d;
      inj_done_q <= inj_done_d;
      inj_dbl_q <= inj_dbl_d;
      inj_pos_a_q <= inj_pos_a_d;
      inj_pos_b_q <= inj_pos_b_d;
      enc_cnt_q <= enc_cnt_d;
    end
  end
endmodule

// File: tb/tb_ecc_26_enc_pipe.sv
// tb_ecc_26_enc_pipe: directed self-checking bench for ecc_26_enc_pipe
module tb_ecc_26_enc_pipe;
  localparam logic [5:0] CODES [26] = '{
    6'h23, 6'h25, 6'h26, 6'h07, 6'h29, 6'h2A, 6'h0B, 6'h2C, 6'h0D, 6'h0E, 6'h2F, 6'h31, 6'h32,
    6'h13, 6'h34, 6'h15, 6'h16, 6'h37, 6'h38, 6'h19, 6'h1A, 6'h3B, 6'h1C, 6'h3D, 6'h3E, 6'h1F
  };
  logic clk, rst_n, inj_arm, inj_dbl, inj_pending, inj_done, clr_cnt;
  logic [4:0] inj_pos_a, inj_pos_b;
  logic [15:0] enc_cnt;
  int checks = 0;
  int errors = 0;
  ecc_26_enc_pipe_if bus ();
  ecc_26_enc_pipe dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .inj_arm(inj_arm), .inj_dbl(inj_dbl), .inj_pos_a(inj_pos_a), .inj_pos_b(inj_pos_b),
    .inj_pending(inj_pending), .inj_done(inj_done), .clr_cnt(clr_cnt), .enc_cnt(enc_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic dbit_err(input logic [25:0] d, input logic [5:0] p);
    logic [5:0] syn;
    syn = p;
    for (int i = 0; i < 26; i++) syn = syn ^ (d[i] ? CODES[i] : 6'h00);
    return syn != 6'h00 && ^syn == 1'b0;
  endfunction
  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 26'h0 || bus.out_parity !== 6'h0 || inj_pending !== 1'b0 || inj_done !== 1'b0 || enc_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset got v=%b d=%h p=%h pend=%b done=%b cnt=%h exp all zero", bus.out_valid, bus.out_data, bus.out_parity, inj_pending, inj_done, enc_cnt);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b v=%b exp rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
  endtask
  task automatic test_encode();
    logic [25:0] dv [7] = '{26'h0000001, 26'h3FFFFFF, 26'h0000000, 26'h0000003, 26'h2000000, 26'h0000400, 26'h0000410};
    logic [5:0] pv [7] = '{6'h23, 6'h3F, 6'h00, 6'h06, 6'h1F, 6'h2F, 6'h06};
    bus.out_ready = 1;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_data !== dv[i-1] || bus.out_parity !== pv[i-1]) begin
          errors++;
          $display("FAIL encode[%0d] got v=%b rdy=%b d=%h p=%h exp v=1 rdy=1 d=%h p=%h", i - 1, bus.out_valid, bus.in_ready, bus.out_data, bus.out_parity, dv[i-1], pv[i-1]);
        end
      end
      if (i < 7) begin
        bus.in_valid = 1;
        bus.in_data = dv[i];
      end else bus.in_valid = 0;
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || enc_cnt !== 16'd7) begin
      errors++;
      $display("FAIL encode_drain got v=%b cnt=%0d exp v=0 cnt=7", bus.out_valid, enc_cnt);
    end
  endtask
  task automatic test_inj_single();
    @(negedge clk);
    inj_arm = 1; inj_dbl = 0; inj_pos_a = 5'd3; inj_pos_b = 5'd0;
    @(negedge clk);
    inj_arm = 0;
    checks++;
    if (inj_pending !== 1'b1) begin
      errors++;
      $display("FAIL inj_arm got pend=%b exp 1", inj_pending);
    end
    bus.in_valid = 1; bus.in_data = 26'h0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 26'h0000008 || bus.out_parity !== 6'h00 || inj_done !== 1'b1 || inj_pending !== 1'b0) begin
      errors++;
      $display("FAIL inj_single got v=%b d=%h p=%h done=%b pend=%b exp v=1 d=0000008 p=00 done=1 pend=0", bus.out_valid, bus.out_data, bus.out_parity, inj_done, inj_pending);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 26'h0 || bus.out_parity !== 6'h00 || inj_done !== 1'b0) begin
      errors++;
      $display("FAIL inj_next_clean got v=%b d=%h p=%h done=%b exp v=1 d=0 p=00 done=0", bus.out_valid, bus.out_data, bus.out_parity, inj_done);
    end
    bus.in_valid = 0;
    @(negedge clk);
  endtask
  task automatic test_inj_double();
    inj_arm = 1; inj_dbl = 1; inj_pos_a = 5'd0; inj_pos_b = 5'd27;
    @(negedge clk);
    inj_arm = 0;
    bus.in_valid = 1; bus.in_data = 26'h0;
    @(negedge clk);
    bus.in_valid = 0;
    checks++;
    if (bus.out_data !== 26'h0000001 || bus.out_parity !== 6'h02 || dbit_err(bus.out_data, bus.out_parity) !== 1'b1) begin
      errors++;
      $display("FAIL inj_double got d=%h p=%h dbit=%b exp d=0000001 p=02 dbit=1", bus.out_data, bus.out_parity, dbit_err(bus.out_data, bus.out_parity));
    end
    @(negedge clk);
    inj_arm = 1; inj_dbl = 1; inj_pos_a = 5'd30; inj_pos_b = 5'd30;
    @(negedge clk);
    inj_arm = 0;
    bus.in_valid = 1; bus.in_data = 26'h0;
    @(negedge clk);
    bus.in_valid = 0;
    checks++;
    if (bus.out_data !== 26'h0 || bus.out_parity !== 6'h10) begin
      errors++;
      $display("FAIL inj_same_pos got d=%h p=%h exp d=0000000 p=10", bus.out_data, bus.out_parity);
    end
    @(negedge clk);
  endtask
  task automatic test_inj_rearm();
    inj_arm = 1; inj_dbl = 1; inj_pos_a = 5'd5; inj_pos_b = 5'd9;
    @(negedge clk);
    inj_dbl = 0; inj_pos_a = 5'd7; inj_pos_b = 5'd0;
    @(negedge clk);
    inj_arm = 0;
    bus.in_valid = 1; bus.in_data = 26'h0;
    @(negedge clk);
    bus.in_valid = 0;
    checks++;
    if (bus.out_data !== 26'h0000080 || bus.out_parity !== 6'h00) begin
      errors++;
      $display("FAIL inj_overwrite got d=%h p=%h exp d=0000080 p=00", bus.out_data, bus.out_parity);
    end
    inj_arm = 1; inj_pos_a = 5'd1;
    @(negedge clk);
    inj_pos_a = 5'd2;
    bus.in_valid = 1; bus.in_data = 26'h0;
    @(negedge clk);
    inj_arm = 0;
    checks++;
    if (bus.out_data !== 26'h0000002 || inj_done !== 1'b1 || inj_pending !== 1'b1) begin
      errors++;
      $display("FAIL inj_rearm_apply got d=%h done=%b pend=%b exp d=0000002 done=1 pend=1", bus.out_data, inj_done, inj_pending);
    end
    @(negedge clk);
    bus.in_valid = 0;
    checks++;
    if (bus.out_data !== 26'h0000004 || inj_done !== 1'b1 || inj_pending !== 1'b0) begin
      errors++;
      $display("FAIL inj_rearm_second got d=%h done=%b pend=%b exp d=0000004 done=1 pend=0", bus.out_data, inj_done, inj_pending);
    end
    @(negedge clk);
  endtask
  task automatic test_backpressure();
    clr_cnt = 1;
    @(negedge clk);
    clr_cnt = 0;
    checks++;
    if (enc_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_cnt got cnt=%0d exp 0", enc_cnt);
    end
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 26'h0000001;
    @(negedge clk);
    bus.in_data = 26'h2000000;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_data !== 26'h0000001 || bus.out_parity !== 6'h23) begin
      errors++;
      $display("FAIL bp_one got v=%b rdy=%b d=%h p=%h exp v=1 rdy=1 d=0000001 p=23", bus.out_valid, bus.in_ready, bus.out_data, bus.out_parity);
    end
    @(negedge clk);
    bus.in_data = 26'h3FFFFFF;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_data !== 26'h0000001 || bus.out_parity !== 6'h23 || enc_cnt !== 16'd2) begin
        errors++;
        $display("FAIL bp_full[%0d] got rdy=%b d=%h p=%h cnt=%0d exp rdy=0 d=0000001 p=23 cnt=2", i, bus.in_ready, bus.out_data, bus.out_parity, enc_cnt);
      end
      @(negedge clk);
    end
    bus.out_ready = 1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_data !== 26'h0000001) begin
      errors++;
      $display("FAIL bp_hold got rdy=%b d=%h exp rdy=0 d=0000001", bus.in_ready, bus.out_data);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_data !== 26'h2000000 || bus.out_parity !== 6'h1F || enc_cnt !== 16'd2) begin
      errors++;
      $display("FAIL bp_drain_b got rdy=%b d=%h p=%h cnt=%0d exp rdy=1 d=2000000 p=1F cnt=2", bus.in_ready, bus.out_data, bus.out_parity, enc_cnt);
    end
    @(negedge clk);
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 26'h3FFFFFF || bus.out_parity !== 6'h3F || enc_cnt !== 16'd3) begin
      errors++;
      $display("FAIL bp_drain_c got v=%b d=%h p=%h cnt=%0d exp v=1 d=3FFFFFF p=3F cnt=3", bus.out_valid, bus.out_data, bus.out_parity, enc_cnt);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty got v=%b exp 0", bus.out_valid);
    end
  endtask
  task automatic test_reset_mid();
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 26'h0000001;
    @(negedge clk);
    bus.in_data = 26'h0000002;
    @(negedge clk);
    bus.in_valid = 0;
    inj_arm = 1; inj_dbl = 0; inj_pos_a = 5'd0;
    @(negedge clk);
    inj_arm = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || inj_pending !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup got v=%b rdy=%b pend=%b exp v=1 rdy=0 pend=1", bus.out_valid, bus.in_ready, inj_pending);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || inj_pending !== 1'b0 || enc_cnt !== 16'd0 || bus.out_data !== 26'h0) begin
      errors++;
      $display("FAIL mid_reset got v=%b pend=%b cnt=%0d d=%h exp v=0 pend=0 cnt=0 d=0", bus.out_valid, inj_pending, enc_cnt, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1;
    bus.out_ready = 1;
    bus.in_valid = 1; bus.in_data = 26'h0000001;
    @(negedge clk);
    bus.in_valid = 0;
    checks++;
    if (bus.out_data !== 26'h0000001 || bus.out_parity !== 6'h23 || inj_done !== 1'b0 || enc_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mid_after got d=%h p=%h done=%b cnt=%0d exp d=0000001 p=23 done=0 cnt=1", bus.out_data, bus.out_parity, inj_done, enc_cnt);
    end
    @(negedge clk);
  endtask
  task automatic test_clr_sat();
    bus.out_ready = 1;
    bus.in_valid = 1; bus.in_data = 26'h0;
    clr_cnt = 1;
    @(negedge clk);
    clr_cnt = 0;
    checks++;
    if (enc_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_priority got cnt=%0d exp 0", enc_cnt);
    end
    repeat (65537) @(negedge clk);
    checks++;
    if (enc_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_saturate got cnt=%h exp FFFF", enc_cnt);
    end
    clr_cnt = 1;
    @(negedge clk);
    clr_cnt = 0;
    checks++;
    if (enc_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_from_sat got cnt=%h exp 0000", enc_cnt);
    end
    @(negedge clk);
    bus.in_valid = 0;
    checks++;
    if (enc_cnt !== 16'd1) begin
      errors++;
      $display("FAIL cnt_after_clr got cnt=%0d exp 1", enc_cnt);
    end
  endtask
  initial begin
    clk = 0; rst_n = 0;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    inj_arm = 0; inj_dbl = 0; inj_pos_a = '0; inj_pos_b = '0; clr_cnt = 0;
    test_reset();
    test_encode();
    test_inj_single();
    test_inj_double();
    test_inj_rearm();
    test_backpressure();
    test_reset_mid();
    test_clr_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ecc_26_enc_pipe.md
ECC_26_ENC_PIPE -- requirements
Module: ecc_26_enc_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 26, data bits per word.
REQ-002 Parameter PARITY_WIDTH, default 6, SECDED check bits per word.
REQ-003 Single clock; reset asynchronous, active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  async active-low reset.
REQ-006 in_valid  input  1  write-side word offered.
REQ-007 in_ready  output  1  block accepts word this cycle.
REQ-008 in_data  input  26  raw data.
REQ-009 out_valid  output  1  encoded word available.
REQ-010 out_ready  input  1  downstream (FIFO write port) accepts.
REQ-011 out_data  output  26  data field of codeword.
REQ-012 out_parity  output  6  parity field of codeword.
REQ-013 inj_arm  input  1  one-cycle pulse arming error injection.
REQ-014 inj_dbl  input  1  sampled with inj_arm: 0 single-bit flip, 1 double-bit flip.
REQ-015 inj_pos_a, inj_pos_b  input  5 each  codeword bit positions (0-25 data, 26-31 parity[0..5]), sampled with inj_arm.
REQ-016 inj_pending  output  1  injection armed, not yet applied.
REQ-017 inj_done  output  1  one-cycle pulse when injection applied.
REQ-018 clr_cnt  input  1  synchronous clear of enc_cnt.
REQ-019 enc_cnt  output  16  count of words accepted.

Function
REQ-020 Parity bit k SHALL equal XOR of in_data[i] for every i whose column code has bit k set; column codes (hex, d0..d25): 23 25 26 07 29 2A 0B 2C 0D 0E 2F 31 32 13 34 15 16 37 38 19 1A 3B 1C 3D 3E 1F.
REQ-021 Word accepted when in_valid && in_ready; encoding and injection computed combinationally at acceptance and registered.
REQ-022 Storage: 2-entry buffer; in_ready = buffer not full (registered, no combinational path from out_ready).
REQ-023 Latency: accepted word presented on out_valid the next cycle when buffer was empty.
REQ-024 Full throughput: with out_ready held 1, one word per cycle sustained.
REQ-025 out_data/out_parity SHALL hold stable while out_valid && !out_ready; order preserved.
REQ-026 Simultaneous accept and drain with buffer full SHALL NOT occur (in_ready=0); with one entry, both in same cycle keeps occupancy 1.
REQ-027 inj_arm sets inj_pending and latches inj_dbl/positions; arm while pending overwrites latched values.
REQ-028 Pending injection applied to next accepted word only: flip pos_a; if inj_dbl also flip pos_b; pos_a==pos_b with inj_dbl flips once.
REQ-029 On application inj_pending clears, inj_done pulses one cycle; inj_arm in that same cycle re-arms (pending stays 1).
REQ-030 enc_cnt increments per accepted word, saturates at 0xFFFF; clr_cnt has priority over increment.

Reset
REQ-031 On rst_n low: buffer empty, out_valid=0, in_ready=1 after release, out_data=0, out_parity=0, inj_pending=0, inj_done=0, latched injection fields=0, enc_cnt=0.
REQ-032 Reset mid-operation SHALL discard buffered words and pending injection.

Structure
REQ-033 Package ecc_26_pkg holds DATA_WIDTH, PARITY_WIDTH, column-code table, codeword bit-position constants.
REQ-034 Combinational encoder as sub-module ecc_26_enc (data in, parity out), instantiated once.

Verification
REQ-035 in_data=0x0000001, out_ready=1 -> next cycle out_valid=1, out_parity=0x23.
REQ-036 in_data=0x3FFFFFF -> out_parity=0x3F; in_data=0 -> out_parity=0x00.
REQ-037 inj_arm, inj_dbl=0, pos_a=3, then in_data=0 -> out_data=0x0000008, out_parity=0x00, inj_done pulse, next word unmodified.
REQ-038 inj_arm, inj_dbl=1, pos_a=0, pos_b=27, in_data=0 -> out_data=0x0000001, out_parity=0x02; codeword fed to checker reports dbit_err=1.
REQ-039 out_ready=0, 3 words offered -> 2 accepted, in_ready=0, outputs stable; out_ready=1 -> words drain in order, enc_cnt=3 after third accept.
REQ-040 rst_n asserted with 2 words buffered and injection pending -> out_valid=0, inj_pending=0, enc_cnt=0 immediately.
